// File: rtl/adc_conversion_sequencer_pkg.sv
// Shared definitions for the ADC conversion sequencer and other phase consumers:
// sequencer state encoding, pixel-window bound helpers and index-width helper.
package cubesat_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_PULSE
    } seq_state_e;

    // First counter value inside the pixel window (one cycle early so the
    // registered edge detector is primed when the first pixel arrives).
    function automatic longint win_lo_bound(input int cyc, input int pre);
        return longint'(cyc) * longint'(pre) - 1;
    endfunction

    // First counter value past the pixel window.
    function automatic longint win_hi_bound(input int cyc, input int pre, input int npix);
        return longint'(cyc) * (longint'(pre) + longint'(npix));
    endfunction

    // Width of a pixel index, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_conversion_sequencer_phase_edge_detect.sv
// Registers a CCD phase once and flags its falling edge (registered-high,
// current-low). Shared by every block that reacts to a phase transition.
module phase_edge_detect (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_phase,
    output logic o_fall
);

    logic phase_q;

    // One-cycle history of the phase.
    always_ff @(posedge i_clock) begin
        if (i_reset) phase_q <= 1'b0;
        else         phase_q <= i_phase;
    end

    assign o_fall = phase_q & ~i_phase;

endmodule

// File: rtl/adc_conversion_sequencer.sv
// Multi-channel ADC start-conversion sequencer. Inside the pixel window each
// qualified phi_l2 falling edge produces one delayed, fixed-width start pulse
// on every enabled channel, with pixel indexing and frame-done strobe.
// Optional feature macro: ADC_SEQ_OVERRUN_EN (busy-channel skip + sticky
// overrun flags); when undefined, o_overrun is tied low and i_adc_busy unused.
module adc_conversion_sequencer
    import cubesat_adc_pkg::*;
#(
    parameter int CICLOS_FORMAS_DE_ONDA = 8,
    parameter int PRE_PIXELS            = 5,
    parameter int N_PIXELS              = 2048,
    parameter int N_CHANNELS            = 4,
    parameter int CNT_W                 = 32,
    parameter int DLY_W                 = 4
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_enable,
    input  logic                           i_phi_l2,
    input  logic [CNT_W-1:0]               contador,
    input  logic [DLY_W-1:0]               i_delay,
    input  logic [DLY_W-1:0]               i_pulse_width,
    input  logic [N_CHANNELS-1:0]          i_channel_mask,
    input  logic [N_CHANNELS-1:0]          i_adc_busy,
    output logic [N_CHANNELS-1:0]          o_adc_start_conversion,
    output logic [idx_width(N_PIXELS)-1:0] o_pixel_index,
    output logic                           o_pixel_valid,
    output logic                           o_frame_done,
    output logic [N_CHANNELS-1:0]          o_overrun
);

    localparam int               IDX_W   = idx_width(N_PIXELS);
    localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(win_lo_bound(CICLOS_FORMAS_DE_ONDA, PRE_PIXELS));
    localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(win_hi_bound(CICLOS_FORMAS_DE_ONDA, PRE_PIXELS, N_PIXELS));
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_PIXELS - 1);

    seq_state_e            state_q;
    logic [DLY_W-1:0]      dly_q;
    logic [DLY_W-1:0]      wid_q;
    logic [N_CHANNELS-1:0] mask_q;
    logic [N_CHANNELS-1:0] start_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic                  win_q;
    logic                  pv_q;
    logic                  fd_q;

    logic                  phi_fall;
    logic                  win;
    logic                  fall;
    logic                  pulse_entry;
    logic [DLY_W-1:0]      pw_eff;
    logic [DLY_W-1:0]      ent_wid;
    logic [N_CHANNELS-1:0] ent_mask;
    logic [N_CHANNELS-1:0] skip;

    phase_edge_detect u_phi_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_phase (i_phi_l2),
        .o_fall  (phi_fall)
    );

    assign win  = (contador >= WIN_LO) && (contador < WIN_HI);
    assign fall = phi_fall & win;

    // A zero width still yields a single-cycle pulse.
    assign pw_eff = (i_pulse_width == '0) ? DLY_W'(1) : i_pulse_width;

    // Settings latched at DELAY entry are reused on the way into PULSE;
    // a zero-delay edge takes them straight from the inputs.
    assign ent_mask = (state_q == ST_DELAY) ? mask_q : i_channel_mask;
    assign ent_wid  = (state_q == ST_DELAY) ? wid_q  : pw_eff;

    assign pulse_entry = i_enable && win &&
                         (((state_q == ST_ARMED) && fall && (i_delay == '0)) ||
                          ((state_q == ST_DELAY) && (dly_q == DLY_W'(1))));

    assign idx_d = (idx_q == IDX_MAX) ? idx_q : idx_q + IDX_W'(1);

`ifdef ADC_SEQ_OVERRUN_EN
    logic [N_CHANNELS-1:0] ovr_q;
    logic                  edge_busy;

    assign skip      = ent_mask & i_adc_busy;
    assign edge_busy = i_enable && fall && ((state_q == ST_DELAY) || (state_q == ST_PULSE));

    // Sticky overrun: busy channels skipped at pulse entry, or an edge that
    // arrives while the previous pixel is still being serviced.
    always_ff @(posedge i_clock) begin
        if (i_reset || !i_enable) ovr_q <= '0;
        else ovr_q <= ovr_q | (pulse_entry ? skip : '0) | (edge_busy ? mask_q : '0);
    end

    assign o_overrun = ovr_q;
`else
    logic [N_CHANNELS-1:0] unused_busy;

    assign unused_busy = i_adc_busy;
    assign skip        = '0;
    assign o_overrun   = '0;
`endif

    // Sequencer FSM with registered outputs; enable and window aborts win.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
            wid_q   <= '0;
            mask_q  <= '0;
            start_q <= '0;
            idx_q   <= '0;
            win_q   <= 1'b0;
            pv_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            pv_q  <= 1'b0;
            win_q <= win;
            fd_q  <= win_q & ~win & i_enable;

            if (!win)             idx_q <= '0;
            else if (pulse_entry) idx_q <= idx_d;

            if (!i_enable) begin
                state_q <= ST_IDLE;
                start_q <= '0;
            end else if (!win) begin
                state_q <= ST_ARMED;
                start_q <= '0;
            end else if (pulse_entry) begin
                state_q <= ST_PULSE;
                mask_q  <= ent_mask;
                wid_q   <= ent_wid;
                start_q <= ent_mask & ~skip;
                pv_q    <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE:  state_q <= ST_ARMED;
                    ST_ARMED: if (fall) begin
                        state_q <= ST_DELAY;
                        dly_q   <= i_delay;
                        mask_q  <= i_channel_mask;
                        wid_q   <= pw_eff;
                    end
                    ST_DELAY: dly_q <= dly_q - DLY_W'(1);
                    ST_PULSE: if (wid_q <= DLY_W'(1)) begin
                        start_q <= '0;
                        state_q <= ST_ARMED;
                    end else begin
                        wid_q <= wid_q - DLY_W'(1);
                    end
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_adc_start_conversion = start_q;
    assign o_pixel_index          = idx_q;
    assign o_pixel_valid          = pv_q;
    assign o_frame_done           = fd_q;

endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// Bench for adc_conversion_sequencer at default parameters. A scheduled-interval
// reference model predicts every output each cycle; directed segments add
// hand-computed literal checks.
module tb_adc_conversion_sequencer;

    logic        clk = 1'b0;
    logic        rst, en, phi;
    logic [31:0] cnt;
    logic [3:0]  dly, pw, mask, busy;
    logic [3:0]  start, ovr;
    logic [10:0] idx;
    logic        pv, fd;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    adc_conversion_sequencer dut (
        .i_clock                (clk),
        .i_reset                (rst),
        .i_enable               (en),
        .i_phi_l2               (phi),
        .contador               (cnt),
        .i_delay                (dly),
        .i_pulse_width          (pw),
        .i_channel_mask         (mask),
        .i_adc_busy             (busy),
        .o_adc_start_conversion (start),
        .o_pixel_index          (idx),
        .o_pixel_valid          (pv),
        .o_frame_done           (fd),
        .o_overrun              (ovr)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted edge becomes an absolute interval
    // [ps, pe) of output cycles carrying the latched mask.
    int       m_k = 0, m_ps = 0, m_pe = 0, e_idx = 0;
    bit       m_pend = 0, m_idle = 1, m_phi = 0, m_win = 0, m_w, m_f;
    bit       e_pv = 0, e_fd = 0;
    logic [3:0] m_mask = 0, m_skip = 0, e_start = 0, e_ovr = 0;

    always @(posedge clk) begin
        m_k = m_k + 1;
        if (rst) begin
            m_pend = 0; m_idle = 1; m_phi = 0; m_win = 0; m_skip = 0;
            e_start = 0; e_pv = 0; e_fd = 0; e_idx = 0; e_ovr = 0;
        end else begin
            m_w  = (cnt >= 32'd39) && (cnt < 32'd16424);
            m_f  = m_phi && !phi && m_w;
            e_pv = 0;
            e_fd = m_win && !m_w && en;
            if (!en) begin
                m_pend = 0; m_idle = 1; e_ovr = 0;
            end else if (!m_w) begin
                m_pend = 0; m_idle = 0;
            end else if (m_idle) begin
                m_idle = 0;
            end else if (m_f) begin
                if (m_pend && m_k < m_pe) begin
`ifdef ADC_SEQ_OVERRUN_EN
                    e_ovr = e_ovr | m_mask;
`endif
                end else begin
                    m_ps   = m_k + 1 + int'(dly);
                    m_pe   = m_ps + ((pw == 0) ? 1 : int'(pw));
                    m_mask = mask;
                    m_pend = 1;
                end
            end
            if (m_pend && m_k + 1 == m_ps) begin
                e_pv = 1;
`ifdef ADC_SEQ_OVERRUN_EN
                m_skip = m_mask & busy;
                e_ovr  = e_ovr | m_skip;
`else
                m_skip = 0;
`endif
                e_idx = (e_idx >= 2047) ? 2047 : e_idx + 1;
            end
            if (!m_w) e_idx = 0;
            e_start = (m_pend && m_k + 1 >= m_ps && m_k + 1 < m_pe) ? (m_mask & ~m_skip) : 4'h0;
            m_phi = phi;
            m_win = m_w;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("start", int'(start), int'(e_start));
            chk("valid", int'(pv), int'(e_pv));
            chk("done", int'(fd), int'(e_fd));
            chk("index", int'(idx), e_idx);
            chk("overrun", int'(ovr), int'(e_ovr));
        end
    end

    int         seg_pv, seg_hi;
    logic [3:0] first_start;

    task automatic drive(input int c, input bit p, input int n);
        for (int i = 0; i < n; i++) begin
            cnt = 32'(c);
            phi = p;
            @(negedge clk);
            if (pv) seg_pv++;
            if (start != 4'h0) seg_hi++;
            if (i == 0) first_start = start;
        end
    endtask

    task automatic seg_clear();
        seg_pv = 0;
        seg_hi = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int n_pv, n_full, n_part, n_fd, first_pv_c, last_pv_c, fd_c, idx_before, idx_after;

    initial begin
        rst = 1; en = 0; phi = 0; cnt = 0; dly = 0; pw = 0; mask = 0; busy = 0;
        seg_clear();
        drive(0, 0, 2);
        chk_on = 1'b1;
        chk("rst_start", int'(start), 0);
        chk("rst_index", int'(idx), 0);
        chk("rst_valid", int'(pv), 0);
        chk("rst_done", int'(fd), 0);
        chk("rst_overrun", int'(ovr), 0);

        // Nominal line: edges every 8 cycles at contador % 8 == 0.
        rst = 0; en = 1; dly = 2; pw = 3; mask = 4'hF;
        n_pv = 0; n_full = 0; n_part = 0; n_fd = 0;
        first_pv_c = -1; last_pv_c = -1; fd_c = -1; idx_before = -1; idx_after = -1;
        for (int c = 0; c <= 16430; c++) begin
            cnt = 32'(c);
            phi = c[2];
            @(negedge clk);
            if (pv) begin
                n_pv++;
                if (n_pv == 1) first_pv_c = c;
                last_pv_c = c;
            end
            if (start == 4'hF) n_full++;
            else if (start != 4'h0) n_part++;
            if (fd) begin n_fd++; fd_c = c; end
            if (c == 16423) idx_before = int'(idx);
            if (c == 16424) idx_after = int'(idx);
        end
        chk("line_pulses", n_pv, 2048);
        chk("line_first_pv", first_pv_c, 42);
        chk("line_last_pv", last_pv_c, 16418);
        chk("line_high_cycles", n_full, 6144);
        chk("line_partial_mask", n_part, 0);
        chk("line_frame_done_cnt", n_fd, 1);
        chk("line_frame_done_at", fd_c, 16424);
        chk("line_index_end", idx_before, 2047);
        chk("line_index_cleared", idx_after, 0);

        // Window edges.
        dly = 1; pw = 2; mask = 4'hF;
        drive(37, 1, 2);
        seg_clear(); drive(38, 0, 4);
        chk("win38_pulses", seg_pv, 0);
        drive(38, 1, 1);
        seg_clear(); drive(39, 0, 6);
        chk("win39_pulses", seg_pv, 1);
        chk("win39_high", seg_hi, 2);
        drive(16423, 1, 2);
        seg_clear(); drive(16424, 0, 4);
        chk("win16424_pulses", seg_pv, 0);

        // Zero delay and width.
        dly = 0; pw = 0;
        drive(100, 1, 1);
        seg_clear(); drive(100, 0, 5);
        chk("zero_first", int'(first_start), 'hF);
        chk("zero_pulses", seg_pv, 1);
        chk("zero_high", seg_hi, 1);

        // Enable dropped mid-pulse, then an edge during the IDLE cycle.
        dly = 1; pw = 4;
        drive(200, 1, 1);
        drive(200, 0, 2);
        chk("abort_in_pulse", int'(start), 'hF);
        en = 0;
        drive(200, 0, 1);
        chk("abort_start", int'(start), 0);
        chk("abort_overrun", int'(ovr), 0);
        drive(200, 1, 1);
        en = 1;
        seg_clear(); drive(200, 0, 4);
        chk("idle_edge_ignored", seg_hi, 0);

        // Reset during DELAY.
        dly = 3; pw = 2;
        drive(300, 1, 1);
        drive(300, 0, 1);
        rst = 1;
        drive(300, 0, 1);
        chk("rstdly_start", int'(start), 0);
        chk("rstdly_valid", int'(pv), 0);
        chk("rstdly_index", int'(idx), 0);
        rst = 0;
        seg_clear(); drive(300, 0, 8);
        chk("rstdly_no_pulse", seg_hi, 0);

        // Mask change during PULSE.
        dly = 0; pw = 3; mask = 4'b0011;
        drive(400, 1, 1);
        drive(400, 0, 1);
        chk("mask_first", int'(first_start), 'h3);
        mask = 4'b1000;
        drive(400, 0, 2);
        chk("mask_held", int'(start), 'h3);
        drive(400, 0, 1);
        chk("mask_pulse_end", int'(start), 0);
        drive(400, 1, 1);
        drive(400, 0, 1);
        chk("mask_next", int'(first_start), 'h8);
        drive(400, 0, 3);

`ifdef ADC_SEQ_OVERRUN_EN
        // Busy channel skipped and flagged; flag sticky until disable.
        dly = 0; pw = 2; mask = 4'hF; busy = 4'b0100;
        drive(600, 1, 1);
        drive(600, 0, 1);
        chk("ovr_skip", int'(first_start), 'hB);
        chk("ovr_flag", int'(ovr), 'h4);
        busy = 4'b0000;
        drive(600, 0, 2);
        drive(600, 1, 1);
        drive(600, 0, 1);
        chk("ovr_next_full", int'(first_start), 'hF);
        chk("ovr_sticky", int'(ovr), 'h4);
        en = 0;
        drive(600, 0, 1);
        chk("ovr_cleared", int'(ovr), 0);
        en = 1;
`endif

        drive(700, 1, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_conversion_sequencer.md
# adc_conversion_sequencer

Parametrised multi-channel successor to the single-output ADC start-conversion generator in the CCD readout path. It watches the shared waveform cycle counter and the `phi_l2` clock phase, and opens a pixel window after a configurable number of pre-scan pixels. Inside the window it issues one programmable-delay, programmable-width start pulse per pixel to every enabled ADC channel. It also tracks the pixel index, flags frame completion and, optionally, reports ADC overruns.

## Interface
**Parameters**
- `CICLOS_FORMAS_DE_ONDA`, default 8: clock cycles per pixel waveform.
- `PRE_PIXELS`, default 5: pre-scan pixels before the window opens.
- `N_PIXELS`, default 2048: pixels per line inside the window.
- `N_CHANNELS`, default 4: number of ADC start outputs.
- `CNT_W`, default 32: width of the cycle counter.
- `DLY_W`, default 4: width of the delay and pulse-width fields.

**Ports**
- `i_clock` in 1: single clock; all logic on its rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_enable` in 1: block enable; low aborts everything.
- `i_phi_l2` in 1: CCD phase; its falling edge schedules a conversion.
- `contador` in `CNT_W`: waveform cycle counter, free-running from the timing generator.
- `i_delay` in `DLY_W`: cycles from the detected edge to the pulse start.
- `i_pulse_width` in `DLY_W`: pulse length in cycles; 0 is treated as 1.
- `i_channel_mask` in `N_CHANNELS`: 1 enables a channel.
- `i_adc_busy` in `N_CHANNELS`: per-channel ADC busy.
- `o_adc_start_conversion` out `N_CHANNELS`: registered start pulses.
- `o_pixel_index` out `clog2(N_PIXELS)`: index of the last issued pixel.
- `o_pixel_valid` out 1: one-cycle strobe on the first cycle of each pulse.
- `o_frame_done` out 1: one-cycle strobe when the window closes.
- `o_overrun` out `N_CHANNELS`: sticky per-channel overrun flags.

## Operation
- Window:
  - `win = (contador >= CICLOS_FORMAS_DE_ONDA*PRE_PIXELS-1) && (contador < CICLOS_FORMAS_DE_ONDA*(PRE_PIXELS+N_PIXELS))`.
  - Compute the bounds as constants in `CNT_W` bits.
  - The comparison is unsigned.
- `phi_l2` is registered once into `phi_q`. A falling edge is `phi_q & ~i_phi_l2`, qualified by `win`.
- FSM states:
  - **IDLE**: go to ARMED when `i_enable` is high.
  - **ARMED**: on a qualified edge, load the delay counter with `i_delay` and go to DELAY. If `i_delay == 0`, go directly to PULSE.
  - **DELAY**: decrement; at 1, go to PULSE.
  - **PULSE**: drive `o_adc_start_conversion = i_channel_mask & ~skip`, where `skip` is latched on pulse entry. Hold for `max(i_pulse_width, 1)` cycles, then return to ARMED.
- Abort: `~i_enable` or `~win` in any state returns the FSM to IDLE or ARMED respectively, with outputs low from the next cycle. A pulse in progress is truncated.
- Edges in DELAY or PULSE are ignored.
- `i_delay`, `i_pulse_width` and `i_channel_mask` are sampled when DELAY or PULSE is entered; changes take effect on the next pixel.
- Pixel index:
  - Cleared while `~win`.
  - Increments on each PULSE entry and saturates at `N_PIXELS-1`.
  - `o_pixel_valid` pulses for one cycle on PULSE entry.
- `o_frame_done` pulses for one cycle on the `win` 1→0 transition while enabled.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE and `phi_q` to 0.
- Edge-to-pulse latency:
  - `i_phi_l2` sampled low in cycle N (with `phi_q = 1`) gives a pulse high from cycle N+1+`i_delay` (outputs registered).
  - With delay 0, the pulse is high at N+1.
- The pulse is high for exactly `max(i_pulse_width,1)` cycles unless aborted.
- Reset asserted mid-pulse drives all outputs low at that same clock edge.
- When a pixel index of `N_PIXELS-1` coincides with the window close, `o_frame_done` and the index clear in the same cycle.

## Configuration
`ADC_SEQ_OVERRUN_EN`:
- **Defined**:
  - On PULSE entry, any masked channel with `i_adc_busy = 1` is skipped (its start stays low) and its `o_overrun` bit is set.
  - A qualified edge arriving in DELAY or PULSE sets all masked `o_overrun` bits.
  - Flags clear on reset or on `~i_enable`.
- **Undefined**: `skip = 0`, `i_adc_busy` is ignored and `o_overrun` is tied to 0.

## Structure
- Shared package `cubesat_adc_pkg` holds:
  - the FSM state enum (IDLE, ARMED, DELAY, PULSE);
  - the window bound constant functions;
  - the index-width helper.
- Sub-module `phase_edge_detect` (register plus falling-edge strobe) is reused by other phase consumers.

## Test plan
1. **Nominal line**: defaults, mask 4'b1111, delay 2, width 3, `phi_l2` toggled every 4 cycles over a full line → 2048 pulses on all channels, each starting 3 cycles after the edge sample and 3 cycles wide; index ends at 2047; `o_frame_done` once.
2. **Window edges**: edge with `contador = 38` → no pulse; edge with `contador = 39` → pulse; edge with `contador = 16424` → no pulse.
3. **Zero fields**: delay 0, width 0 → a 1-cycle pulse one cycle after the edge sample.
4. **Abort**: `i_enable` dropped mid-PULSE → outputs 0 next cycle, FSM to IDLE, `o_overrun` cleared. Reset mid-DELAY → all outputs 0, no later pulse.
5. **Overrun (macro defined)**: `i_adc_busy = 4'b0100` at PULSE entry → channel 2 start stays low and `o_overrun = 4'b0100`; the flag stays sticky until `~i_enable`.
6. **Mask change**: mask changed from 4'b0011 to 4'b1000 during PULSE → current pulse keeps 4'b0011; the next pixel uses 4'b1000.
